// File: rtl/read_mem_send_pkg.sv
// read_mem_send_pkg: shared widths, sizes and FSM encoding for the
// coefficient read-out path.
package read_mem_send_pkg;
    localparam int COEF_W = 23;
    localparam int N_COEF = 256;
    localparam int N_BEAT = 128;
    localparam int ADDR_W = 8;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
endpackage

// File: rtl/read_mem_send_coef_pair_fifo.sv
// coef_pair_fifo: small first-word fall-through FIFO of coefficient pairs;
// the head entry is read straight out of the register array.
module coef_pair_fifo
    import read_mem_send_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W = 2 * COEF_W,
    parameter int CW = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [W-1:0]  din,
    input  logic          pop,
    output logic [W-1:0]  dout,
    output logic [CW-1:0] count
);
    localparam int PW = $clog2(DEPTH);
    logic [W-1:0] mem_q [DEPTH];
    logic [W-1:0] mem_d [DEPTH];
    logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0] count_q, count_d;
    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction
    always_comb begin
        mem_d = mem_q;
        if (push) mem_d[wr_q] = din;
        wr_d = push ? nxt(wr_q) : wr_q;
        rd_d = pop ? nxt(rd_q) : rd_q;
        count_d = count_q + CW'(push) - CW'(pop);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q   <= '{default: '0};
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            mem_q   <= mem_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
        end
    end
    assign dout  = mem_q[rd_q];
    assign count = count_q;
endmodule

// File: rtl/read_mem_send.sv
// read_mem_send: reads a 256-coefficient polynomial from the dual-port BRAM as
// address pairs and streams each pair as one beat into the output FIFO.
module read_mem_send
    import read_mem_send_pkg::*;
#(
    parameter int RD_LAT = 2,
    parameter int BUF_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              module_start,
    output logic              coef_ena,
    output logic [ADDR_W-1:0] coef_addra,
    input  logic [COEF_W-1:0] coef_douta,
    output logic              coef_enb,
    output logic [ADDR_W-1:0] coef_addrb,
    input  logic [COEF_W-1:0] coef_doutb,
    input  logic              Wm_tready,
    output logic              Wm_tvalid,
    output logic [COEF_W-1:0] data_out_1,
    output logic [COEF_W-1:0] data_out_2,
    output logic              Wm_tlast,
    output logic              module_done
);
    localparam int CW = $clog2(BUF_DEPTH + 1);
    localparam int BW = $clog2(N_BEAT);
    state_t state_q, state_d;
    logic [BW-1:0] iss_q, iss_d, acc_q, acc_d;
    logic [RD_LAT-1:0] pipe_q, pipe_d;
    logic [CW-1:0] fill;
    logic [2*COEF_W-1:0] head;
    logic hs, credit;
    // Reads in flight plus buffered beats must fit the buffer, so returning data always has a slot.
    assign credit = $countones(pipe_q) + int'(fill) < BUF_DEPTH;
    assign hs = Wm_tvalid & Wm_tready;
    always_comb begin
        state_d  = state_q;
        coef_ena = state_q == RUN && credit;
        iss_d    = coef_ena ? iss_q + BW'(1) : iss_q;
        acc_d    = hs ? acc_q + BW'(1) : acc_q;
        pipe_d   = RD_LAT'({pipe_q, coef_ena});
        case (state_q)
            IDLE:    if (module_start) state_d = RUN;
            RUN:     if (coef_ena && iss_q == BW'(N_BEAT - 1)) state_d = DRAIN;
            // Leave as the final beat is accepted so completion lands one cycle after it.
            DRAIN:   if (pipe_q == '0 && (fill == '0 || (fill == CW'(1) && hs))) state_d = DONE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            iss_q   <= '0;
            acc_q   <= '0;
            pipe_q  <= '0;
        end else begin
            state_q <= state_d;
            iss_q   <= iss_d;
            acc_q   <= acc_d;
            pipe_q  <= pipe_d;
        end
    end
    coef_pair_fifo #(.DEPTH(BUF_DEPTH), .W(2 * COEF_W), .CW(CW)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (pipe_q[RD_LAT-1]),
        .din   ({coef_douta, coef_doutb}),
        .pop   (hs),
        .dout  (head),
        .count (fill)
    );
    assign coef_enb    = coef_ena;
    assign coef_addra  = {iss_q, 1'b0};
    assign coef_addrb  = {iss_q, coef_ena};
    assign Wm_tvalid   = fill != '0;
    assign data_out_1  = head[2*COEF_W-1:COEF_W];
    assign data_out_2  = head[COEF_W-1:0];
    assign Wm_tlast    = acc_q == BW'(N_BEAT - 1);
    assign module_done = state_q == DONE;
endmodule

// File: tb/tb_read_mem_send.sv
// tb_read_mem_send: three DUT configurations against a BRAM model and an
// ordered-beat scoreboard for the default instance.
module tb_read_mem_send;
    localparam int NI = 3;
    typedef struct {
        int cyc; int ena; int addr; int valid; int d1; int d2; int last; int done;
    } vec_t;
    logic clk = 0, rst = 1, start = 0, ready = 0;
    logic ena [NI], enb [NI], valid [NI], last [NI], done [NI];
    logic [7:0] addra [NI], addrb [NI];
    logic [22:0] douta [NI], doutb [NI], d1 [NI], d2 [NI];
    logic [22:0] mem [256];
    vec_t tbl [11];
    int nchk = 0, nerr = 0;
    int k = 0, iss = 0, acc = 0;
    bit hold = 0, last_hs = 0, hl = 0;
    logic [22:0] h1 = 0, h2 = 0;
    int dc;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : gi
        localparam int L = g == 1 ? 1 : g == 2 ? 3 : 2;
        localparam int D = g == 1 ? 3 : g == 2 ? 5 : 4;
        logic [22:0] pa [L];
        logic [22:0] pb [L];
        always @(posedge clk) begin
            if (ena[g]) pa[0] <= mem[addra[g]];
            if (enb[g]) pb[0] <= mem[addrb[g]];
            for (int i = 1; i < L; i++) begin
                pa[i] <= pa[i-1];
                pb[i] <= pb[i-1];
            end
        end
        assign douta[g] = pa[L-1];
        assign doutb[g] = pb[L-1];
        read_mem_send #(.RD_LAT(L), .BUF_DEPTH(D)) dut (
            .clk(clk), .rst(rst), .module_start(start),
            .coef_ena(ena[g]), .coef_addra(addra[g]), .coef_douta(douta[g]),
            .coef_enb(enb[g]), .coef_addrb(addrb[g]), .coef_doutb(doutb[g]),
            .Wm_tready(ready), .Wm_tvalid(valid[g]),
            .data_out_1(d1[g]), .data_out_2(d2[g]),
            .Wm_tlast(last[g]), .module_done(done[g])
        );
    end

    task automatic chk(input string name, input int act, input int exp);
        nchk++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: the n-th read of a run targets (2n, 2n+1); the k-th beat carries mem[2k], mem[2k+1].
    always @(negedge clk) begin
        if (rst) begin
            k = 0; iss = 0; acc = 0; hold = 0; last_hs = 0;
        end else begin
            if (ena[0]) begin
                chk("credit", int'(iss - acc < 4), 1);
                chk("enb", int'(enb[0]), 1);
                chk("addra", int'(addra[0]), 2 * iss);
                chk("addrb", int'(addrb[0]), 2 * iss + 1);
                iss++;
            end
            if (hold)
                chk("stable", int'({valid[0], last[0], d1[0], d2[0]} == {1'b1, hl, h1, h2}), 1);
            if (last_hs || done[0]) chk("done_latency", int'(last_hs && done[0]), 1);
            last_hs = 0;
            if (valid[0] && ready) begin
                chk("beat_d1", int'(d1[0]), k < 128 ? int'(mem[2*k]) : -1);
                chk("beat_d2", int'(d2[0]), k < 128 ? int'(mem[2*k+1]) : -1);
                chk("tlast", int'(last[0]), int'(k == 127));
                k++; acc++;
                last_hs = k == 128;
            end
            if (done[0]) begin
                chk("beat_count", k, 128);
                k = 0; iss = 0; acc = 0;
            end
            hold = valid[0] && !ready;
            hl = last[0]; h1 = d1[0]; h2 = d2[0];
        end
    end

    task automatic run(input int stall, input int pct, input int extra, input int abort_k,
                       input bit tbl_on, output int dcyc);
        int first [NI];
        int nb [NI];
        int lastc [NI];
        dcyc = -1;
        for (int g = 0; g < NI; g++) begin first[g] = -1; nb[g] = 0; lastc[g] = -1; end
        @(posedge clk); #1;
        start = 1;
        ready = stall > 0 ? 1'b0 : 1'($urandom_range(0, 99) < pct);
        for (int c = 0; c < 3000 && (dcyc < 0 || c <= dcyc + 1) && k < abort_k; c++) begin
            @(negedge clk); #1;
            if (done[0] && dcyc < 0) dcyc = c;
            if (c == stall - 1) chk("stall_reads", iss, 4);
            if (stall > 0 && c >= 4 && c < stall)
                chk("stall_head", int'(valid[0] && d1[0] == mem[0] && d2[0] == mem[1]), 1);
            if (tbl_on) begin
                foreach (tbl[i]) if (tbl[i].cyc == c) begin
                    chk("t_ena", int'(ena[0]), tbl[i].ena);
                    if (tbl[i].ena != 0) chk("t_addr", int'(addra[0]), tbl[i].addr);
                    chk("t_valid", int'(valid[0]), tbl[i].valid);
                    if (tbl[i].valid != 0) begin
                        chk("t_d1", int'(d1[0]), tbl[i].d1);
                        chk("t_d2", int'(d2[0]), tbl[i].d2);
                        chk("t_last", int'(last[0]), tbl[i].last);
                    end
                    chk("t_done", int'(done[0]), tbl[i].done);
                end
                for (int g = 1; g < NI; g++) if (valid[g]) begin
                    if (first[g] < 0) first[g] = c;
                    chk("sweep_d1", int'(d1[g]), 2 * (c - first[g]));
                    chk("sweep_d2", int'(d2[g]), 2 * (c - first[g]) + 1);
                    nb[g]++;
                    lastc[g] = c;
                end
            end
            @(posedge clk); #1;
            start = c + 1 == extra;
            ready = c + 1 < stall ? 1'b0 : 1'($urandom_range(0, 99) < pct);
        end
        if (abort_k > 200) chk("finished", int'(dcyc >= 0), 1);
        if (tbl_on)
            for (int g = 1; g < NI; g++) begin
                chk("sweep_first", first[g], g == 1 ? 3 : 5);
                chk("sweep_beats", nb[g], 128);
                chk("sweep_span", lastc[g] - first[g], 127);
            end
    endtask

    task automatic check_quiet(input string name);
        chk({name, "_ena"}, int'(ena[0]), 0);
        chk({name, "_valid"}, int'(valid[0]), 0);
        chk({name, "_done"}, int'(done[0]), 0);
    endtask

    initial begin
        tbl = '{'{0, 0, 0, 0, 0, 0, 0, 0}, '{1, 1, 0, 0, 0, 0, 0, 0},
                '{2, 1, 2, 0, 0, 0, 0, 0}, '{3, 1, 4, 0, 0, 0, 0, 0},
                '{4, 1, 6, 1, 0, 1, 0, 0}, '{5, 1, 8, 1, 2, 3, 0, 0},
                '{128, 1, 254, 1, 248, 249, 0, 0}, '{129, 0, 0, 1, 250, 251, 0, 0},
                '{131, 0, 0, 1, 254, 255, 1, 0}, '{132, 0, 0, 0, 0, 0, 0, 1},
                '{133, 0, 0, 0, 0, 0, 0, 0}};
        foreach (mem[i]) mem[i] = 23'(i);
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int g = 0; g < NI; g++) chk("rst_ena", int'(ena[g] | enb[g]), 0);
        chk("rst_addr", int'({addra[0], addrb[0]}), 0);
        chk("rst_out", int'({valid[0], last[0], done[0]}), 0);
        chk("rst_data", int'(d1[0] | d2[0]), 0);
        @(posedge clk); #1 rst = 0;

        run(0, 100, -1, 1000, 1, dc);
        chk("done_cycle_full", dc, 132);

        foreach (mem[i]) mem[i] = 23'($urandom);
        run(20, 100, -1, 1000, 0, dc);

        for (int r = 0; r < 2; r++) begin
            foreach (mem[i]) mem[i] = 23'($urandom);
            run(0, 30, 60, 1000, 0, dc);
        end

        foreach (mem[i]) mem[i] = 23'($urandom);
        run(0, 100, 20, 51, 0, dc);
        rst = 1; ready = 1;
        @(posedge clk); #1 rst = 0;
        @(negedge clk); #1;
        check_quiet("after_rst");
        chk("after_rst_data", int'(d1[0] | d2[0]), 0);
        chk("after_rst_last", int'(last[0]), 0);
        repeat (4) begin
            @(negedge clk); #1;
            check_quiet("late_data");
        end
        run(0, 100, -1, 1000, 0, dc);
        chk("done_cycle_restart", dc, 132);

        @(posedge clk); #1 rst = 1; start = 1;
        @(posedge clk); #1 rst = 0; start = 0;
        repeat (3) begin
            @(negedge clk); #1;
            check_quiet("rst_start");
        end

        run(0, 100, -1, 1000, 0, dc);
        chk("done_cycle_final", dc, 132);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
